// File: rtl/ebpf_alu_pkg.sv
// Shared types and elaboration helpers for the eBPF execute-stage ALU blocks.
// The control word travels beside the data through every shift stage.
package ebpf_alu_pkg;

  localparam int TAG_MAX_W = 16;

  typedef enum logic [1:0] {
    SHIFT_LSH  = 2'b00,
    SHIFT_RSH  = 2'b01,
    SHIFT_ARSH = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_e;

  typedef struct packed {
    shift_op_e              op;
    logic                   alu32;
    logic                   sign;
    logic [TAG_MAX_W-1:0]   tag;
  } shift_ctl_t;

  // Pipeline stage that owns barrel level lvl.
  function automatic int stage_of_level(input int lvl, input int stages, input int levels);
    return (lvl * stages) / levels;
  endfunction

  function automatic int level_lo(input int stg, input int stages, input int levels);
    int lo;
    lo = levels;
    for (int l = levels - 1; l >= 0; l--) begin
      if (stage_of_level(l, stages, levels) == stg) lo = l;
    end
    return lo;
  endfunction

  function automatic int level_hi(input int stg, input int stages, input int levels);
    int hi;
    hi = -1;
    for (int l = 0; l < levels; l++) begin
      if (stage_of_level(l, stages, levels) == stg) hi = l;
    end
    return hi;
  endfunction

endpackage

// File: rtl/ebpf_shift_stage.sv
// One elastic pipeline slice of the shift unit: applies barrel levels
// LVL_LO..LVL_HI to the incoming operand and registers the result.
module ebpf_shift_stage
  import ebpf_alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [$clog2(DATA_W)-1:0]   in_amt,
  input  shift_ctl_t                  in_ctl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(DATA_W)-1:0]   out_amt,
  output shift_ctl_t                  out_ctl
);

  localparam int LEVELS = $clog2(DATA_W);

  logic                vld_p0;
  logic                adv;
  logic [DATA_W-1:0]   shifted;

  // Right shifts fill vacated bits with the carried sign (0 for logical).
  function automatic logic [DATA_W-1:0] shift_level(
    input logic [DATA_W-1:0] d,
    input int                lvl,
    input shift_op_e         op,
    input logic              sign
  );
    logic [DATA_W-1:0] fill;
    fill = {DATA_W{sign}} & ~({DATA_W{1'b1}} >> (1 << lvl));
    if (op == SHIFT_LSH) return d << (1 << lvl);
    return (d >> (1 << lvl)) | fill;
  endfunction

  always_comb begin
    shifted = in_data;
    for (int l = 0; l < LEVELS; l++) begin
      if (l >= LVL_LO && l <= LVL_HI && in_amt[l]) begin
        shifted = shift_level(shifted, l, in_ctl.op, in_ctl.sign);
      end
    end
  end

  assign adv       = ~vld_p0 | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p0;

  // Stage register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      out_data <= '0;
      out_amt  <= '0;
      out_ctl  <= '0;
    end else begin
      if (flush) begin
        vld_p0 <= 1'b0;
      end else if (adv) begin
        vld_p0 <= in_valid;
      end
      if (adv && in_valid && !flush) begin
        out_data <= shifted;
        out_amt  <= in_amt;
        out_ctl  <= in_ctl;
      end
    end
  end

endmodule

// File: rtl/ebpf_shift_unit.sv
// Pipelined elastic eBPF shift unit (LSH/RSH/ARSH, ALU64 and ALU32 forms).
// Operand preparation here, barrel levels spread over STAGES slices.
module ebpf_shift_unit
  import ebpf_alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic                in_alu32,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_err
);

  localparam int LEVELS = $clog2(DATA_W);

  logic                alu32_eff;
  shift_op_e           op_in;
  logic                sign_in;
  logic [DATA_W-1:0]   a_ext;
  logic [LEVELS-1:0]   amt_in;
  shift_ctl_t          ctl_in;

  logic                vld_p [STAGES+1];
  logic                rdy_p [STAGES+1];
  logic [DATA_W-1:0]   data_p [STAGES+1];
  logic [LEVELS-1:0]   amt_p [STAGES+1];
  shift_ctl_t          ctl_p [STAGES+1];

  shift_ctl_t          ctl_out;
  logic [DATA_W-1:0]   res_out;

  // ALU32 right shifts run on a sign/zero-extended copy so the wide
  // barrel fills the low word correctly; the upper word is dropped at the end.
  always_comb begin
    op_in     = shift_op_e'(in_op);
    alu32_eff = (DATA_W > 32) ? in_alu32 : 1'b0;
    sign_in   = (op_in == SHIFT_ARSH) && (alu32_eff ? in_a[31] : in_a[DATA_W-1]);
    a_ext     = in_a;
    if (alu32_eff) begin
      for (int i = 32; i < DATA_W; i++) a_ext[i] = sign_in;
    end
    amt_in = in_b[LEVELS-1:0];
    if (alu32_eff) amt_in = amt_in & LEVELS'(5'd31);
    ctl_in                  = '0;
    ctl_in.op               = op_in;
    ctl_in.alu32            = alu32_eff;
    ctl_in.sign             = sign_in;
    ctl_in.tag[TAG_W-1:0]   = in_tag;
  end

  assign vld_p[0]       = in_valid & ~flush;
  assign data_p[0]      = a_ext;
  assign amt_p[0]       = amt_in;
  assign ctl_p[0]       = ctl_in;
  assign rdy_p[STAGES]  = out_ready;
  assign in_ready       = rdy_p[0] & ~flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ebpf_shift_stage #(
      .DATA_W (DATA_W),
      .LVL_LO (level_lo(k, STAGES, LEVELS)),
      .LVL_HI (level_hi(k, STAGES, LEVELS))
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (vld_p[k]),
      .in_ready  (rdy_p[k]),
      .in_data   (data_p[k]),
      .in_amt    (amt_p[k]),
      .in_ctl    (ctl_p[k]),
      .out_valid (vld_p[k+1]),
      .out_ready (rdy_p[k+1]),
      .out_data  (data_p[k+1]),
      .out_amt   (amt_p[k+1]),
      .out_ctl   (ctl_p[k+1])
    );
  end

  // Output mux: reserved op forces zero, ALU32 zero-extends the low word.
  always_comb begin
    ctl_out = ctl_p[STAGES];
    res_out = data_p[STAGES];
    if (ctl_out.alu32) begin
      for (int i = 32; i < DATA_W; i++) res_out[i] = 1'b0;
    end
    if (ctl_out.op == SHIFT_RSVD) res_out = '0;
  end

  assign out_valid  = vld_p[STAGES];
  assign out_result = res_out;
  assign out_tag    = ctl_out.tag[TAG_W-1:0];
  assign out_err    = (ctl_out.op == SHIFT_RSVD);

endmodule

// File: tb/tb_ebpf_shift_unit.sv
// Scoreboard bench for ebpf_shift_unit: directed cases plus randomized traffic
// checked against an arithmetic reference model.
module tb_ebpf_shift_unit;

  localparam int DATA_W = 64;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_op;
  logic                in_alu32;
  logic [DATA_W-1:0]   in_a;
  logic [DATA_W-1:0]   in_b;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_result;
  logic [TAG_W-1:0]    out_tag;
  logic                out_err;

  ebpf_shift_unit #(.DATA_W(DATA_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_alu32(in_alu32),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [TAG_W-1:0]  tag;
    logic              err;
    int                acc_cyc;
    bit                chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cnt  = 0;
  bit   lat_mode = 1'b1;
  bit   stop_rnd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: eBPF shift semantics in plain arithmetic.
  function automatic void model(input logic [1:0] op, input logic alu32,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output logic err);
    logic [31:0] x;
    logic [31:0] r32;
    int unsigned s;
    err = 1'b0;
    res = '0;
    if (op == 2'b11) begin
      err = 1'b1;
    end else if (alu32) begin
      x = a[31:0];
      s = int'(b % 64'd32);
      case (op)
        2'b00:   r32 = x << s;
        2'b01:   r32 = x >> s;
        default: r32 = 32'($signed(x) >>> s);
      endcase
      res = {32'h0, r32};
    end else begin
      s = int'(b % 64'd64);
      case (op)
        2'b00:   res = a << s;
        2'b01:   res = a >> s;
        default: res = 64'($signed(a) >>> s);
      endcase
    end
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Monitor: pops an expectation for every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got result=%h tag=%0d err=%b, required no output",
                   out_result, out_tag, out_err);
        end else begin
          e = sb.pop_front();
          if (out_result !== e.res || out_tag !== e.tag || out_err !== e.err) begin
            n_fail++;
            $display("FAIL result: got result=%h tag=%0d err=%b, required result=%h tag=%0d err=%b",
                     out_result, out_tag, out_err, e.res, e.tag, e.err);
          end
          if (e.chk_lat) begin
            n_checks++;
            if (cyc - e.acc_cyc != STAGES) begin
              n_fail++;
              $display("FAIL latency: got %0d cycles, required %0d", cyc - e.acc_cyc, STAGES);
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic alu32, input logic [63:0] a,
                       input logic [63:0] b, input logic [TAG_W-1:0] tag,
                       input logic [63:0] er, input logic ee);
    exp_t e;
    int   w;
    bit   done;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_alu32 = alu32; in_a = a; in_b = b; in_tag = tag;
    w = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = er; e.tag = tag; e.err = ee; e.acc_cyc = cyc; e.chk_lat = lat_mode;
        sb.push_back(e);
        acc_cnt++;
        done = 1'b1;
      end else begin
        w++;
        if (w > 300) begin
          n_checks++; n_fail++;
          $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required acceptance", w);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic drive_model(input logic [1:0] op, input logic alu32, input logic [63:0] a,
                             input logic [63:0] b, input logic [TAG_W-1:0] tag);
    logic [63:0] r;
    logic        e;
    model(op, alu32, a, b, r, e);
    drive(op, alu32, a, b, tag, r, e);
  endtask

  task automatic drive_rand(input logic [TAG_W-1:0] tag);
    logic [63:0] a;
    logic [63:0] b;
    a = {$urandom, $urandom};
    b = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
    drive_model(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b, tag);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_alu32 = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_result", out_result, 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("reset_out_err", 64'(out_err), 64'd0);
    rst_n = 1'b1;

    // Directed cases with exact latency
    lat_mode = 1'b1;
    drive(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drive(2'b10, 1'b1, 64'h1234_5678_8000_0010, 64'd36, 4'd2, 64'h0000_0000_F800_0001, 1'b0);
    drive(2'b00, 1'b0, 64'd1, 64'd65, 4'd3, 64'd2, 1'b0);
    drive(2'b01, 1'b0, 64'hF0, 64'd4, 4'd4, 64'h0F, 1'b0);
    drive(2'b11, 1'b0, 64'd5, 64'd1, 4'd5, 64'd0, 1'b1);
    drive(2'b00, 1'b1, 64'hFFFF_FFFF_8000_0001, 64'd33, 4'd6, 64'h0000_0000_0000_0002, 1'b0);
    idle();
    drain();

    // Backpressure: fill with out_ready low, then release
    lat_mode = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_rand(TAG_W'(i));
        idle();
      end
      begin
        repeat (10) @(negedge clk);
        #1;
        check("bp_accepts", 64'(acc_cnt), 64'(STAGES));
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        nv = 0;
        repeat (8) begin
          @(negedge clk);
          if (out_valid) nv++;
        end
        check("bp_no_gaps", 64'(nv), 64'd8);
      end
    join
    drain();

    // Flush with the pipe full and an input offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_rand(TAG_W'(8 + i));
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_alu32 = 1'b0;
    in_a = 64'd9; in_b = 64'd0; in_tag = 4'd15;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    lat_mode = 1'b1;
    drive(2'b00, 1'b0, 64'd3, 64'd1, 4'd12, 64'd6, 1'b0);
    idle();
    drain();

    // Asynchronous reset with results waiting
    lat_mode = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_rand(4'd13);
    drive_rand(4'd14);
    idle();
    repeat (4) @(negedge clk);
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_out_result", out_result, 64'd0);
    check("async_reset_out_tag", 64'(out_tag), 64'd0);
    check("async_reset_out_err", 64'(out_err), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);
    lat_mode = 1'b1;
    drive_model(2'b10, 1'b0, 64'hC000_0000_0000_0000, 64'd2, 4'd7);
    idle();
    drain();

    // Randomized traffic with random backpressure
    lat_mode = 1'b0;
    fork
      begin
        while (!stop_rnd) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      drive_rand(TAG_W'($urandom));
    end
    idle();
    stop_rnd = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
